// File: rtl/xfer_tx_buffer.sv
// Host-read transfer buffer: the device fills fixed-size word buffers, the host drains
// them one word per request over the shared bus, and a setup query reports full buffers.
module xfer_tx_buffer #(
    parameter int NUM_BUF   = 2,
    parameter int BUF_DEPTH = 1024
) (
    input  logic        clock_host,
    input  logic        reset,
    input  logic        host_select,
    input  logic        hread_enable,
    inout  wire  [31:0] hostdata_inout,
    output logic        hread_valid,
    output logic        hread_underrun,
    input  logic        gs_select,
    input  logic        gs_write_enable,
    output logic [7:0]  gs_out,
    output logic        gs_out_enable,
    input  logic        dev_wr_valid,
    input  logic [31:0] dev_wr_data,
    output logic        dev_wr_ready
);
    localparam int PW     = $clog2(BUF_DEPTH);
    localparam int BW     = $clog2(NUM_BUF);
    localparam int CW     = $clog2(NUM_BUF + 1);
    localparam int STAGES = 1;
    localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_BUF);

    typedef enum logic [1:0] {Q_IDLE, Q_RESP, Q_WAIT_REL} q_state_t;

    logic [31:0]     mem [NUM_BUF*BUF_DEPTH];
    logic [31:0]     ram_q, hdata_q;
    logic [BW-1:0]   fill_buf, read_buf;
    logic [PW-1:0]   fill_ptr, read_ptr;
    logic [CW-1:0]   ready_cnt, ready_nxt;
    logic [STAGES:0] vld_pipe, urn_pipe;
    logic            wr_acc, rd_req, rd_acc, fill_done, rel_done;
    q_state_t        q_state;

    always_comb begin
        wr_acc    = dev_wr_valid & dev_wr_ready;
        rd_req    = host_select & hread_enable;
        rd_acc    = rd_req & (ready_cnt != '0);
        fill_done = wr_acc & (fill_ptr == LAST);
        rel_done  = rd_acc & (read_ptr == LAST);
        ready_nxt = ready_cnt;
        if (fill_done & ~rel_done)
            ready_nxt = ready_cnt + CW'(1);
        else if (rel_done & ~fill_done)
            ready_nxt = ready_cnt - CW'(1);
    end

    // Fill and read never target the same buffer: fill only runs while a buffer is free.
    always_ff @(posedge clock_host) begin
        if (wr_acc)
            mem[{fill_buf, fill_ptr}] <= dev_wr_data;
        ram_q <= mem[{read_buf, read_ptr}];
    end

    always_ff @(posedge clock_host) begin
        if (reset) begin
            fill_buf     <= '0;
            read_buf     <= '0;
            fill_ptr     <= '0;
            read_ptr     <= '0;
            ready_cnt    <= '0;
            dev_wr_ready <= 1'b1;
            vld_pipe     <= '0;
            urn_pipe     <= '0;
            hdata_q      <= '0;
        end else begin
            if (wr_acc) begin
                fill_ptr <= fill_ptr + PW'(1);
                if (fill_done)
                    fill_buf <= fill_buf + BW'(1);
            end
            if (rd_acc) begin
                read_ptr <= read_ptr + PW'(1);
                if (rel_done)
                    read_buf <= read_buf + BW'(1);
            end
            ready_cnt <= ready_nxt;
            // Registered from the next count so the word after the last free slot is never offered.
            dev_wr_ready <= (ready_nxt != FULL);
            vld_pipe     <= {vld_pipe[STAGES-1:0], rd_acc};
            urn_pipe     <= {urn_pipe[STAGES-1:0], rd_req & ~rd_acc};
            hdata_q      <= ram_q;
        end
    end

    assign hread_valid    = vld_pipe[STAGES];
    assign hread_underrun = urn_pipe[STAGES];
    assign hostdata_inout = hread_valid ? hdata_q : {32{1'bz}};

    // One response per query assertion; the host must drop gs_select to re-arm.
    always_ff @(posedge clock_host) begin
        if (reset) begin
            q_state       <= Q_IDLE;
            gs_out        <= '0;
            gs_out_enable <= 1'b0;
        end else begin
            gs_out_enable <= 1'b0;
            case (q_state)
                Q_IDLE:     if (gs_select && !gs_write_enable) q_state <= Q_RESP;
                Q_RESP: begin
                    gs_out_enable <= 1'b1;
                    gs_out        <= 8'(ready_cnt);
                    q_state       <= Q_WAIT_REL;
                end
                Q_WAIT_REL: if (!gs_select) q_state <= Q_IDLE;
                default:    q_state <= Q_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xfer_tx_buffer.sv
// Bench for xfer_tx_buffer: directed vectors and sequences plus random traffic,
// all compared every cycle against a queue-based model of ready buffers.
module tb_xfer_tx_buffer;
    localparam int NB = 2;
    localparam int D  = 1024;

    logic        clock_host = 1'b0;
    logic        reset = 1'b1;
    logic        host_select = 1'b0, hread_enable = 1'b0;
    logic        gs_select = 1'b0, gs_write_enable = 1'b0;
    logic        dev_wr_valid = 1'b0;
    logic [31:0] dev_wr_data = '0;
    wire  [31:0] hostdata_inout;
    logic        hread_valid, hread_underrun, gs_out_enable, dev_wr_ready;
    logic [7:0]  gs_out;

    xfer_tx_buffer #(.NUM_BUF(NB), .BUF_DEPTH(D)) dut (
        .clock_host(clock_host), .reset(reset),
        .host_select(host_select), .hread_enable(hread_enable),
        .hostdata_inout(hostdata_inout), .hread_valid(hread_valid),
        .hread_underrun(hread_underrun), .gs_select(gs_select),
        .gs_write_enable(gs_write_enable), .gs_out(gs_out),
        .gs_out_enable(gs_out_enable), .dev_wr_valid(dev_wr_valid),
        .dev_wr_data(dev_wr_data), .dev_wr_ready(dev_wr_ready)
    );

    always #5 clock_host = ~clock_host;

    // Undriven bus floats high, so a released bus reads as all ones.
    for (genvar g = 0; g < 32; g++) begin : g_pu
        pullup pu (hostdata_inout[g]);
    end

    typedef struct { bit v; bit u; bit ge; logic [31:0] d; logic [7:0] go; } exp_t;
    typedef struct { bit hs; bit he; bit gs; bit gw; bit ge; bit ur; bit rdy; } vec_t;

    exp_t        cur, nxt;
    int unsigned rdyq[$];
    int unsigned fillq[$];
    bit          armed = 1'b1, skip = 1'b0;
    int          checks = 0, errors = 0, scnt = 0;
    logic [7:0]  last_gs = '0;
    vec_t        tv[8];

    // Ready buffers = words still queued for the host, rounded up to whole buffers.
    function automatic int nrdy();
        return (rdyq.size() + D - 1) / D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rd, acc, fok;
        if (reset) begin
            rdyq.delete();
            fillq.delete();
            cur = '{default: 0};
            nxt = '{default: 0};
            armed = 1'b1;
            skip = 1'b0;
            return;
        end
        rd  = host_select && hread_enable;
        acc = rd && (rdyq.size() > 0);
        fok = dev_wr_valid && (nrdy() != NB);
        cur = nxt;
        nxt = '{default: 0};
        nxt.v = acc;
        nxt.u = rd && !acc;
        if (acc) nxt.d = rdyq.pop_front();
        if (fok) begin
            fillq.push_back(dev_wr_data);
            if (fillq.size() == D) begin
                foreach (fillq[i]) rdyq.push_back(fillq[i]);
                fillq.delete();
            end
        end
        if (armed && gs_select && !gs_write_enable) begin
            nxt.ge = 1'b1;
            nxt.go = 8'(nrdy());
            armed = 1'b0;
            skip = 1'b1;
        end else if (skip) begin
            skip = 1'b0;
        end else if (!armed && !gs_select) begin
            armed = 1'b1;
        end
    endtask

    task automatic check_outs();
        chk("hread_valid", 32'(hread_valid), 32'(cur.v));
        chk("hread_underrun", 32'(hread_underrun), 32'(cur.u));
        chk("gs_out_enable", 32'(gs_out_enable), 32'(cur.ge));
        if (cur.v) chk("rd_data", hostdata_inout, cur.d);
        else       chk("bus_z", hostdata_inout, 32'hFFFF_FFFF);
        if (cur.ge) chk("gs_out", 32'(gs_out), 32'(cur.go));
        chk("dev_wr_ready", 32'(dev_wr_ready), 32'(nrdy() != NB));
        if (gs_out_enable) begin
            scnt++;
            last_gs = gs_out;
        end
    endtask

    task automatic cyc();
        @(posedge clock_host);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic idle();
        host_select = 0; hread_enable = 0; gs_select = 0; gs_write_enable = 0; dev_wr_valid = 0;
    endtask

    task automatic fill(input int unsigned base, input int n);
        dev_wr_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            dev_wr_data = base + i;
            cyc();
        end
        dev_wr_valid = 1'b0;
    endtask

    task automatic rd_words(input int n);
        host_select = 1'b1; hread_enable = 1'b1;
        repeat (n) cyc();
        host_select = 1'b0; hread_enable = 1'b0;
        cyc();
    endtask

    task automatic query(input string tag, input int exp);
        gs_select = 1'b1; gs_write_enable = 1'b0; scnt = 0;
        repeat (3) cyc();
        gs_select = 1'b0;
        repeat (2) cyc();
        chk({tag, "_pulses"}, 32'(scnt), 32'd1);
        chk({tag, "_value"}, 32'(last_gs), 32'(exp));
    endtask

    initial begin
        //        hs he gs gw   ge ur rdy
        tv[0] = '{0, 0, 1, 0,   0, 0, 1};
        tv[1] = '{0, 0, 1, 0,   1, 0, 1};
        tv[2] = '{0, 0, 1, 0,   0, 0, 1};
        tv[3] = '{1, 1, 0, 0,   0, 0, 1};
        tv[4] = '{0, 0, 0, 0,   0, 1, 1};
        tv[5] = '{0, 0, 1, 1,   0, 0, 1};
        tv[6] = '{0, 0, 1, 1,   0, 0, 1};
        tv[7] = '{0, 0, 0, 0,   0, 0, 1};

        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_gs_out", 32'(gs_out), 32'd0);
        chk("rst_wr_ready", 32'(dev_wr_ready), 32'd1);
        chk("rst_bus_z", hostdata_inout, 32'hFFFF_FFFF);

        for (int i = 0; i < 8; i++) begin
            host_select = tv[i].hs; hread_enable = tv[i].he;
            gs_select = tv[i].gs; gs_write_enable = tv[i].gw;
            cyc();
            chk("tv_ge", 32'(gs_out_enable), 32'(tv[i].ge));
            chk("tv_ur", 32'(hread_underrun), 32'(tv[i].ur));
            chk("tv_rdy", 32'(dev_wr_ready), 32'(tv[i].rdy));
            if (tv[i].ge) chk("tv_gs_out", 32'(gs_out), 32'd0);
        end
        idle();

        // Holding the query line yields a single response.
        gs_select = 1'b1; scnt = 0;
        repeat (12) cyc();
        gs_select = 1'b0;
        repeat (2) cyc();
        chk("hold_pulses", 32'(scnt), 32'd1);

        fill(0, D);
        query("q_one", 1);
        rd_words(D);
        query("q_empty", 0);

        // Fill both buffers plus extra words that must be refused.
        fill(0, 2 * D + 5);
        chk("full_ready", 32'(dev_wr_ready), 32'd0);
        query("q_full", 2);
        rd_words(D);
        chk("release_ready", 32'(dev_wr_ready), 32'd1);
        rd_words(D);
        query("q_drained", 0);

        host_select = 1'b1; hread_enable = 1'b1;
        cyc();
        host_select = 1'b0; hread_enable = 1'b0;
        cyc();
        chk("underrun_pulse", 32'(hread_underrun), 32'd1);
        chk("underrun_bus_z", hostdata_inout, 32'hFFFF_FFFF);
        cyc();
        chk("underrun_once", 32'(hread_underrun), 32'd0);
        fill(100, D);
        host_select = 1'b1; hread_enable = 1'b1;
        cyc(); cyc();
        chk("first_word", hostdata_inout, 32'd100);
        repeat (D - 2) cyc();
        idle();
        cyc(); cyc();

        // Last fill word of one buffer lands on the same edge as the last read of the other.
        fill(7000, D);
        dev_wr_valid = 1'b1; host_select = 1'b1; hread_enable = 1'b1;
        for (int i = 0; i < D; i++) begin
            dev_wr_data = 9000 + i;
            cyc();
        end
        idle();
        cyc();
        query("q_simul", 1);
        rd_words(D);
        query("q_simul_done", 0);

        fill(300, D);
        host_select = 1'b1; hread_enable = 1'b1;
        repeat (500) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        idle();
        chk("midrst_valid", 32'(hread_valid), 32'd0);
        chk("midrst_bus_z", hostdata_inout, 32'hFFFF_FFFF);
        cyc();
        query("q_after_rst", 0);
        fill(4000, D);
        rd_words(D);

        for (int i = 0; i < 6000; i++) begin
            bit fill_heavy;
            fill_heavy = (i / 1500) % 2 == 0;
            host_select     = ($urandom % 4) != 0;
            hread_enable    = fill_heavy ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            dev_wr_valid    = fill_heavy ? (($urandom % 8) != 0) : (($urandom % 3) == 0);
            dev_wr_data     = $urandom;
            if (($urandom % 8) == 0) gs_select = ~gs_select;
            gs_write_enable = ($urandom % 4) == 0;
            reset           = ($urandom % 2000) == 0;
            cyc();
        end
        reset = 1'b0;
        idle();
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
